// File: rtl/dmem_load_responder.sv
// Direct-mapped single-word load responder in front of a backing memory.
// Hits respond one cycle after the handshake. A miss fetches a single word
// from the backing memory, installs it, and then responds. Only one miss can
// be outstanding at a time. Stores merge into an entry on a tag hit and never
// allocate. A backend flush squashes any load response that is still pending.
module dmem_load_responder #(
   parameter int ENTRIES = 8,
   parameter int IDX     = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        backend_flush,
   // load request / response
   input  logic        dmem_valid,
   output logic        dmem_ready,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   output logic        dmem_resp,
   output logic [31:0] dmem_rdata,
   // store update
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [3:0]  wr_wmask,
   input  logic [31:0] wr_wdata,
   // backing memory
   output logic        bmem_read,
   input  logic        bmem_ready,
   output logic [31:0] bmem_addr,
   input  logic        bmem_rvalid,
   input  logic [31:0] bmem_rdata
);

   localparam int TAG_W = 30 - IDX;

   typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT, MISS_RESP} state_t;

   state_t             state, state_next;
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [31:0]        data_mem [ENTRIES];

   logic [31:0]        miss_addr;
   logic               kill;
   logic               hit_resp;
   logic [31:0]        resp_data;

   logic [IDX-1:0]     ld_idx, wr_idx, miss_idx;
   logic [TAG_W-1:0]   ld_tag, wr_tag, miss_tag;
   logic               ld_hs, ld_hit, wr_hs, wr_hit, fill;

   // The low address bits are always zero and the read mask never affects
   // lookup; they are collected here so they are visibly intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{dmem_rmask, dmem_addr[1:0], wr_addr[1:0], miss_addr[1:0]};

   // Address decode and hit detection for the load, store and fill paths.
   always_comb begin
      ld_idx   = dmem_addr[IDX+1:2];
      ld_tag   = dmem_addr[31:IDX+2];
      wr_idx   = wr_addr[IDX+1:2];
      wr_tag   = wr_addr[31:IDX+2];
      miss_idx = miss_addr[IDX+1:2];
      miss_tag = miss_addr[31:IDX+2];
      ld_hs    = dmem_valid && dmem_ready;
      ld_hit   = valid[ld_idx] && (tag_mem[ld_idx] == ld_tag);
      wr_hs    = wr_valid && wr_ready;
      wr_hit   = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
      fill     = (state == MISS_WAIT) && bmem_rvalid;
   end

   // State register; reset returns to RUN, abandoning any miss in flight.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // Next-state logic and handshake/response outputs.
   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      dmem_ready = 1'b0;
      wr_ready   = 1'b0;
      bmem_read  = 1'b0;
      bmem_addr  = miss_addr;
      dmem_resp  = 1'b0;
      dmem_rdata = resp_data;
      unique case (state)
         RUN: begin
            wr_ready   = !rst;
            dmem_ready = !rst && !wr_valid;
            dmem_resp  = hit_resp && !backend_flush;
            if (ld_hs && !ld_hit) state_next = MISS_REQ;
         end
         MISS_REQ: begin
            bmem_read = 1'b1;
            if (bmem_ready) state_next = MISS_WAIT;
         end
         MISS_WAIT: begin
            if (bmem_rvalid) state_next = MISS_RESP;
         end
         MISS_RESP: begin
            dmem_resp  = !kill && !backend_flush;
            state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // Kill flag: a flush during an outstanding miss suppresses its response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                   kill <= 1'b0;
      else if (state == MISS_RESP)                               kill <= 1'b0;
      else if ((state == MISS_REQ || state == MISS_WAIT) && backend_flush) kill <= 1'b1;
   end

   // Hit response pipeline register (one response per accepted hit).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hit_resp <= 1'b0;
      else     hit_resp <= ld_hs && ld_hit;
   end

   // Response data and latched miss address; datapath only, no reset needed.
   always_ff @(posedge clk) begin
      if (ld_hs && ld_hit)  resp_data <= data_mem[ld_idx];
      else if (fill)        resp_data <= bmem_rdata;
      if (ld_hs && !ld_hit) miss_addr <= dmem_addr;
   end

   // Valid bits: cleared on reset, set when a fill installs an entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       valid <= '0;
      else if (fill) valid[miss_idx] <= 1'b1;
   end

   // Tag and data storage: fills overwrite the entry, store hits merge bytes.
   // NOTE: the arrays are not reset; the valid bits alone qualify their
   // contents, which keeps them mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= bmem_rdata;
      end else if (wr_hs && wr_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_wmask[b]) data_mem[wr_idx][8*b +: 8] <= wr_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: doc/dmem_load_responder.md
DMEM_LOAD_RESPONDER -- requirements
Module: dmem_load_responder

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, giving the number of direct-mapped word entries; it is a power of two and at least 2.
REQ-002 SHALL have parameter IDX = log2(ENTRIES); index = addr[IDX+1:2] and tag = addr[31:IDX+2].
REQ-003 clk  in  1  the single clock; every register updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 backend_flush  in  1  squashes any load response that is still outstanding.
REQ-006 dmem_valid  in  1  load request from the load queue.
REQ-007 dmem_ready  out  1  the responder can accept a load this cycle.
REQ-008 dmem_addr  in  32  word-aligned load address (bits [1:0] are 0).
REQ-009 dmem_rmask  in  4  byte read mask; it is never zero on a valid request and is not used for lookup.
REQ-010 dmem_resp  out  1  load data is valid this cycle.
REQ-011 dmem_rdata  out  32  full loaded word.
REQ-012 wr_valid / wr_ready  in / out  1 / 1  store-update handshake.
REQ-013 wr_addr  in  32;  wr_wmask  in  4;  wr_wdata  in  32  store word address, byte enables and data.
REQ-014 bmem_read  out  1;  bmem_ready  in  1;  bmem_addr  out  32  backing-memory read request handshake.
REQ-015 bmem_rvalid  in  1;  bmem_rdata  in  32  backing-memory read return.

Function
REQ-016 SHALL hold per entry: a valid bit, a tag and a 32-bit data word.
REQ-017 SHALL use FSM states RUN, MISS_REQ, MISS_WAIT and MISS_RESP.
REQ-018 dmem_ready SHALL be 1 only in RUN with wr_valid=0, so a store update wins over a load.
REQ-019 wr_ready SHALL be 1 only in RUN, and dmem_ready SHALL be 0 in every other state.
REQ-020 A load handshake is dmem_valid && dmem_ready. On a hit, the FSM stays in RUN, dmem_resp=1 exactly 1 cycle later, and dmem_rdata = the entry data.
REQ-021 On a hit, back-to-back handshakes SHALL be accepted every cycle, with one response per cycle in order.
REQ-022 On a miss handshake, the responder SHALL latch the address and go to MISS_REQ.
REQ-023 In MISS_REQ, bmem_read=1 and bmem_addr = the latched address, held stable until bmem_ready; on bmem_ready the FSM goes to MISS_WAIT.
REQ-024 In MISS_WAIT, on bmem_rvalid the responder SHALL write valid, tag and bmem_rdata into the indexed entry (evicting any prior occupant), capture the data, and go to MISS_RESP.
REQ-025 In MISS_RESP, dmem_resp=1 with the captured data unless killed; the FSM then returns to RUN.
REQ-026 A store handshake (wr_valid && wr_ready) SHALL merge wr_wdata into the entry by wr_wmask on a tag hit, and SHALL leave the entry unchanged on a miss (no allocate).
REQ-027 A store merge is visible to a load accepted in the next cycle.
REQ-028 backend_flush=1 in any cycle SHALL force dmem_resp=0 in that cycle.
REQ-029 backend_flush=1 while in MISS_REQ or MISS_WAIT SHALL set a kill flag; the fill still completes and installs, the MISS_RESP response is suppressed, and the flag clears on return to RUN.
REQ-030 A hit response already registered SHALL be dropped if backend_flush=1 in its response cycle.
REQ-031 At most one load SHALL be outstanding to backing memory at a time.
REQ-032 dmem_rdata SHALL be don't-care when dmem_resp=0.

Reset
REQ-033 On rst: all valid bits = 0, FSM = RUN, kill flag = 0.
REQ-034 On rst: dmem_resp=0, bmem_read=0, dmem_ready=0, wr_ready=0, held while rst=1.
REQ-035 rst asserted mid-miss SHALL abandon the miss without any response; a later bmem_rvalid while in RUN SHALL be ignored.

Verification
REQ-036 Cold load addr 0x100 -> bmem_read with bmem_addr=0x100; bmem_rdata=0xDEADBEEF -> dmem_resp with 0xDEADBEEF; a reload of 0x100 responds 1 cycle after the handshake.
REQ-037 Loads 0x100, 0x104, 0x100 on consecutive cycles, all hits -> 3 consecutive responses in order, with no bmem_read.
REQ-038 Entry 0x100=0xDEADBEEF, store wmask=4'b0011 wdata=0x0000CAFE -> next load of 0x100 returns 0xDEADCAFE.
REQ-039 Load 0x100 then 0x120 (ENTRIES=8, same index) -> both miss; then 0x100 misses again (eviction).
REQ-040 Miss to 0x200, backend_flush pulsed in MISS_WAIT -> no dmem_resp; a later load of 0x200 hits with the bmem data.
REQ-041 wr_valid and dmem_valid asserted together in RUN -> the store is accepted and dmem_ready=0; the load is accepted the following cycle.
